// File: rtl/cu_mod0_1.sv
// Control unit for the BF2II (delay-DELAY) butterfly stage of module 0.
// Counts accepted samples and derives butterfly enable, -j select, output strobes and the next-stage alert.
module cu_mod0_1 #(
    parameter int DELAY = 8,
    parameter int FRAME = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic alert_mod01,
    output logic bf_en,
    output logic rot_j,
    output logic valid_fac8_1,
    output logic alert_mod02,
    output logic frame_done
);
    localparam int D  = $clog2(DELAY);
    localparam int CW = $clog2(FRAME);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   k;
    logic            accept;
    logic            sent;

    always_comb begin
        accept    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                accept = valid & alert_mod01;
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                accept = valid;
                if (accept && k == CW'(DELAY - 1)) state_nxt = RUN;
            end
            RUN: accept = valid;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs describe the sample just accepted, so they use k before increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            sent         <= 1'b0;
            bf_en        <= 1'b0;
            rot_j        <= 1'b0;
            valid_fac8_1 <= 1'b0;
            alert_mod02  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            valid_fac8_1 <= 1'b0;
            alert_mod02  <= 1'b0;
            frame_done   <= 1'b0;
            if (accept) begin
                k            <= k + CW'(1);
                bf_en        <= k[D];
                rot_j        <= k[D+1] & ~k[D];
                valid_fac8_1 <= (state == RUN);
                frame_done   <= (k == CW'(FRAME - 1));
                // Only the first RUN sample after a start wakes stage 2.
                if (state == RUN && !sent) begin
                    alert_mod02 <= 1'b1;
                    sent        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cu_mod0_1.sv
// Scoreboard bench for cu_mod0_1 (DELAY=8, FRAME=32): a sample-count reference model
// queues the expected outputs for each driven cycle; they are popped one cycle later.
module tb_cu_mod0_1;
    localparam int DELAY = 8;
    localparam int FRAME = 32;

    typedef struct packed {
        logic bf, rot, vld, alrt, fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst, valid, alert_mod01;
    logic bf_en, rot_j, valid_fac8_1, alert_mod02, frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    // reference model state
    bit   m_started;
    int   m_k;
    int   m_n;     // samples accepted since start
    logic m_bf, m_rot;
    int   alert_cnt;
    int   first_vld_cyc, cyc;

    cu_mod0_1 #(.DELAY(DELAY), .FRAME(FRAME)) dut (
        .clk(clk), .rst(rst), .valid(valid), .alert_mod01(alert_mod01),
        .bf_en(bf_en), .rot_j(rot_j), .valid_fac8_1(valid_fac8_1),
        .alert_mod02(alert_mod02), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic a);
        exp_t e;
        bit   acc;
        rst = r; valid = v; alert_mod01 = a;
        e = '0;
        if (r) begin
            m_started = 0; m_k = 0; m_n = 0; m_bf = 0; m_rot = 0;
        end else begin
            acc = v && (m_started || a);
            if (acc) begin
                m_bf  = (m_k / DELAY) % 2 == 1;
                m_rot = ((m_k / DELAY) % 4) == 2;
                e.vld  = (m_n >= DELAY);
                e.alrt = (m_n == DELAY);
                e.fd   = (m_k == FRAME - 1);
                m_k = (m_k + 1) % FRAME;
                m_n++;
                m_started = 1;
            end
        end
        e.bf = m_bf; e.rot = m_rot;
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() == 0) begin
            chk("queue_underflow", 0, 1);
        end else begin
            e = q.pop_front();
            chk("bf_en",        bf_en,        e.bf);
            chk("rot_j",        rot_j,        e.rot);
            chk("valid_fac8_1", valid_fac8_1, e.vld);
            chk("alert_mod02",  alert_mod02,  e.alrt);
            chk("frame_done",   frame_done,   e.fd);
        end
        if (alert_mod02) alert_cnt++;
        if (valid_fac8_1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    endtask

    initial begin
        int start_cyc;
        rst = 1'b1; valid = 1'b0; alert_mod01 = 1'b0;
        cyc = 0; alert_cnt = 0; first_vld_cyc = -1;
        m_started = 0; m_k = 0; m_n = 0; m_bf = 0; m_rot = 0;
        @(posedge clk); #1;

        // reset, then valid without a start request
        repeat (3) step(1, 0, 0);
        repeat (20) step(0, 1, 0);

        // start with alert held a few cycles (ignored after start), 3 gap-free frames
        start_cyc = cyc;
        alert_cnt = 0; first_vld_cyc = -1;
        repeat (4) step(0, 1, 1);
        repeat (3 * FRAME + 4) step(0, 1, 0);
        chk("alert_once", alert_cnt, 1);
        chk("first_vld_latency", first_vld_cyc - start_cyc, DELAY + 1);

        // random stalls, ~30% gap density
        repeat (200) step(0, ($urandom_range(0, 9) >= 3), 0);
        chk("alert_once_stall", alert_cnt, 1);

        // mid-frame reset at sample 20 after a fresh start
        step(1, 0, 0);
        alert_cnt = 0;
        step(0, 1, 1);
        repeat (19) step(0, 1, 0);
        step(1, 1, 1);
        chk("reset_clears_vld", valid_fac8_1, 0);

        // alert with no valid, then stream: fill must repeat and alert reissue
        alert_cnt = 0; first_vld_cyc = -1;
        repeat (5) step(0, 0, 1);
        start_cyc = cyc;
        repeat (60) step(0, 1, 1);
        chk("alert_reissued", alert_cnt, 1);
        chk("restart_latency", first_vld_cyc - start_cyc, DELAY + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
